// File: rtl/glitch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : glitch_pkg
// Description : Shared types and constants for the glitch pulse generator:
//               FSM state encoding, counter widths, default debounce length
//               and a helper that maps a zero setting to one.
// Revision    : 1.0 - initial release
// ============================================================================
package glitch_pkg;

    localparam int CNT_W                   = 16;
    localparam int REP_W                   = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 2000000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Width and gap settings of zero behave as one cycle.
    function automatic logic [CNT_W-1:0] min_one_cnt(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // A repeat setting of zero behaves as a single pulse.
    function automatic logic [REP_W-1:0] min_one_rep(input logic [REP_W-1:0] v);
        return (v == '0) ? REP_W'(1) : v;
    endfunction

endpackage : glitch_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Multi-flop synchronizer followed by a counter debouncer.
//               The level output flips only after DEBOUNCE_CYCLES consecutive
//               cycles of a synchronized value that differs from it; rise_o
//               strobes for one cycle when the level goes high.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import glitch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   w_sync;

    assign w_sync = sync_q[SYNC_STAGES-1];

    // Shift the raw button through the synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(btn_i);
        end
    end

    // Count consecutive differing samples; accept the new level at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (w_sync != level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    level_q  <= w_sync;
                    rise_q   <= w_sync;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/glitch_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : glitch_pulse_gen
// Description : Button-triggered glitch request generator. A debounced press
//               while armed latches delay/width/gap/repeat and emits a train
//               of registered pulses; one run per press, abortable by
//               dropping the arm enable.
// Revision    : 1.0 - initial release
// ============================================================================
module glitch_pulse_gen
    import glitch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             i_clk,
    input  logic             i_clk_reset,
    input  logic             i_btn,
    input  logic             i_arm_en,
    input  logic [CNT_W-1:0] i_delay,
    input  logic [CNT_W-1:0] i_width,
    input  logic [CNT_W-1:0] i_gap,
    input  logic [REP_W-1:0] i_repeat,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count
);

    logic w_level;
    logic w_rise;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_debounce (
        .clk_i   (i_clk),
        .rst_ni  (i_clk_reset),
        .btn_i   (i_btn),
        .level_o (w_level),
        .rise_o  (w_rise)
    );

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;      // shared delay / width / gap down-counter
    logic [REP_W-1:0] rep_q;      // pulses still to emit, including current
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;

    // Run sequencer: all outputs are registered alongside the state.
    always_ff @(posedge i_clk or negedge i_clk_reset) begin
        if (!i_clk_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rep_q   <= '0;
            width_q <= '0;
            gap_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_rise && i_arm_en) begin
                        width_q <= min_one_cnt(i_width);
                        gap_q   <= min_one_cnt(i_gap);
                        rep_q   <= min_one_rep(i_repeat);
                        busy_q  <= 1'b1;
                        if (i_delay == '0) begin
                            state_q <= ST_PULSE;
                            cnt_q   <= min_one_cnt(i_width);
                            pulse_q <= 1'b1;
                            count_q <= count_q + CNT_W'(1);
                        end else begin
                            state_q <= ST_DELAY;
                            cnt_q   <= i_delay;
                        end
                    end
                end
                ST_DELAY, ST_PULSE, ST_GAP: begin
                    if (!i_arm_en) begin
                        // Abort: park in HOLD without a done strobe.
                        state_q <= ST_HOLD;
                        pulse_q <= 1'b0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        if (state_q == ST_PULSE) begin
                            pulse_q <= 1'b0;
                            if (rep_q == REP_W'(1)) begin
                                state_q <= ST_HOLD;
                                done_q  <= 1'b1;
                            end else begin
                                rep_q   <= rep_q - REP_W'(1);
                                state_q <= ST_GAP;
                                cnt_q   <= gap_q;
                            end
                        end else begin
                            state_q <= ST_PULSE;
                            cnt_q   <= width_q;
                            pulse_q <= 1'b1;
                            count_q <= count_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // Wait for release so a held button yields one run only.
                    if (!w_level) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    pulse_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_pulse = pulse_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_count = count_q;

endmodule : glitch_pulse_gen
`default_nettype wire

// File: tb/tb_glitch_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_glitch_pulse_gen
// Description : Self-checking bench for glitch_pulse_gen (DEBOUNCE_CYCLES=4).
//               A cycle-level reference model derives the pulse schedule by
//               arithmetic from the latched settings; directed vectors and
//               corner sequences are followed by randomized presses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glitch_pulse_gen;

    localparam int DB = 4;

    logic        i_clk = 1'b0;
    logic        i_clk_reset = 1'b0;
    logic        i_btn = 1'b0;
    logic        i_arm_en = 1'b0;
    logic [15:0] i_delay = '0;
    logic [15:0] i_width = '0;
    logic [15:0] i_gap = '0;
    logic [7:0]  i_repeat = '0;
    logic        o_pulse;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_count;

    glitch_pulse_gen #(
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (2)
    ) dut (
        .i_clk       (i_clk),
        .i_clk_reset (i_clk_reset),
        .i_btn       (i_btn),
        .i_arm_en    (i_arm_en),
        .i_delay     (i_delay),
        .i_width     (i_width),
        .i_gap       (i_gap),
        .i_repeat    (i_repeat),
        .o_pulse     (o_pulse),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_count     (o_count)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    int          cyc;
    bit          raw_h0, raw_h1;        // raw button one and two cycles ago
    bit [DB-1:0] win;                   // last DB synchronized samples
    bit          lvl_m, rise_m;
    int          st_m;                  // 0 idle, 1 running, 2 holding
    int          t_m, d_m, w_m, g_m, r_m, run_end_m, hold_start_m;
    bit          aborted_m;
    bit          exp_pulse, exp_busy, exp_done;
    logic [15:0] exp_count;

    task automatic model_reset();
        raw_h0 = 0; raw_h1 = 0; win = '0; lvl_m = 0; rise_m = 0;
        st_m = 0; aborted_m = 0; hold_start_m = -1;
        exp_pulse = 0; exp_busy = 0; exp_done = 0; exp_count = '0;
    endtask

    // Advance the model across one rising edge using the inputs held in the
    // cycle that just ended, then form the expected outputs of the new cycle.
    task automatic model_step();
        bit s;
        int k;
        if (!i_clk_reset) begin
            model_reset();
            cyc++;
            return;
        end
        case (st_m)
            0: if (rise_m && i_arm_en) begin
                t_m = cyc;
                d_m = int'(i_delay);
                w_m = (i_width == 0) ? 1 : int'(i_width);
                g_m = (i_gap == 0) ? 1 : int'(i_gap);
                r_m = (i_repeat == 0) ? 1 : int'(i_repeat);
                run_end_m = t_m + d_m + r_m * w_m + (r_m - 1) * g_m;
                aborted_m = 0;
                st_m = 1;
            end
            1: if (!i_arm_en) begin
                aborted_m = 1; st_m = 2; hold_start_m = cyc + 1;
            end else if (cyc == run_end_m) begin
                st_m = 2; hold_start_m = cyc + 1;
            end
            default: if (!lvl_m) st_m = 0;
        endcase
        s = raw_h1;
        win = {win[DB-2:0], s};
        raw_h1 = raw_h0;
        raw_h0 = i_btn;
        rise_m = 0;
        if (win == {DB{~lvl_m}}) begin
            lvl_m = ~lvl_m;
            rise_m = lvl_m;
        end
        cyc++;
        exp_busy = (st_m != 0);
        exp_done = (st_m == 2) && (cyc == hold_start_m) && !aborted_m;
        exp_pulse = 0;
        if (st_m == 1) begin
            k = cyc - (t_m + 1 + d_m);
            if (k >= 0 && (k % (w_m + g_m)) < w_m) begin
                exp_pulse = 1;
                if ((k % (w_m + g_m)) == 0) exp_count++;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        checks++;
        if ({o_pulse, o_busy, o_done, o_count} !== {exp_pulse, exp_busy, exp_done, exp_count}) begin
            failures++;
            $display("FAIL model cyc=%0d: got pulse=%b busy=%b done=%b count=%h, required pulse=%b busy=%b done=%b count=%h",
                     cyc, o_pulse, o_busy, o_done, o_count, exp_pulse, exp_busy, exp_done, exp_count);
        end
    endtask

    // Per-scenario observations of the DUT outputs.
    int st_high, st_rises, st_dones, st_busy_rises, busy_rise_cyc, first_rise_cyc;
    bit prev_pulse, prev_busy;

    task automatic clear_stats();
        st_high = 0; st_rises = 0; st_dones = 0; st_busy_rises = 0;
        busy_rise_cyc = 0; first_rise_cyc = 0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
        check_outputs();
        if (o_busy && !prev_busy) begin st_busy_rises++; busy_rise_cyc = cyc; end
        if (o_pulse && !prev_pulse) begin
            if (st_rises == 0) first_rise_cyc = cyc;
            st_rises++;
        end
        if (o_pulse) st_high++;
        if (o_done) st_dones++;
        prev_pulse = o_pulse;
        prev_busy = o_busy;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_busy(input bit val, input int budget, input string name);
        int n = 0;
        while (o_busy !== val && n < budget) begin tick(); n++; end
        chk(name, o_busy, val);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (st_dones == 0 && n < budget) begin tick(); n++; end
        chk(name, st_dones, 1);
    endtask

    task automatic wait_rises(input int target, input int budget, input string name);
        int n = 0;
        while (st_rises < target && n < budget) begin tick(); n++; end
        chk(name, st_rises, target);
    endtask

    task automatic set_cfg(input int d, input int w, input int g, input int r);
        i_delay = 16'(d); i_width = 16'(w); i_gap = 16'(g); i_repeat = 8'(r);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int d, w, g, r;
        int exp_off;      // cycles from busy rise to first pulse
        int exp_high;     // total pulse-high cycles
        int exp_n;        // number of pulses
    } vec_t;

    vec_t vec[5];
    logic [15:0] run_total;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, hold, rel;

        vec[0] = '{d: 0,  w: 1, g: 1, r: 1, exp_off: 0,  exp_high: 1,  exp_n: 1};
        vec[1] = '{d: 10, w: 5, g: 3, r: 3, exp_off: 10, exp_high: 15, exp_n: 3};
        vec[2] = '{d: 0,  w: 0, g: 0, r: 0, exp_off: 0,  exp_high: 1,  exp_n: 1};
        vec[3] = '{d: 3,  w: 2, g: 0, r: 2, exp_off: 3,  exp_high: 4,  exp_n: 2};
        vec[4] = '{d: 1,  w: 3, g: 2, r: 4, exp_off: 1,  exp_high: 12, exp_n: 4};

        cyc = 0;
        model_reset();
        prev_pulse = 0; prev_busy = 0;
        clear_stats();
        run_total = '0;

        // Reset held: everything idle and zero.
        ticks(3);
        chk("reset-outputs", {o_pulse, o_busy, o_done, o_count}, 0);
        i_clk_reset = 1'b1;
        i_arm_en = 1'b1;
        ticks(3);

        // Table-driven runs.
        for (int i = 0; i < 5; i++) begin
            set_cfg(vec[i].d, vec[i].w, vec[i].g, vec[i].r);
            clear_stats();
            i_btn = 1'b1;
            wait_busy(1'b1, 40, "vec-trigger");
            wait_done(400, "vec-done");
            ticks(3);
            i_btn = 1'b0;
            wait_busy(1'b0, 40, "vec-idle");
            run_total = run_total + 16'(vec[i].exp_n);
            chk("vec-offset", first_rise_cyc - busy_rise_cyc, vec[i].exp_off);
            chk("vec-high", st_high, vec[i].exp_high);
            chk("vec-pulses", st_rises, vec[i].exp_n);
            chk("vec-done-once", st_dones, 1);
            chk("vec-count", o_count, run_total);
            ticks(2);
        end

        // Bouncing press: one trigger, no retrigger while held, re-press runs again.
        set_cfg(0, 1, 1, 1);
        clear_stats();
        for (int i = 0; i < 30; i++) begin
            i_btn = ((i / 2) % 2) == 0;
            tick();
        end
        i_btn = 1'b1;
        ticks(60);
        chk("bounce-one-trigger", st_busy_rises, 1);
        chk("bounce-held-in-hold", o_busy, 1);
        chk("bounce-one-done", st_dones, 1);
        i_btn = 1'b0;
        wait_busy(1'b0, 40, "bounce-release-idle");
        ticks(2);
        i_btn = 1'b1;
        wait_busy(1'b1, 40, "bounce-repress");
        chk("bounce-second-run", st_busy_rises, 2);
        ticks(5);
        i_btn = 1'b0;
        wait_busy(1'b0, 40, "bounce-idle2");
        run_total = run_total + 16'd2;
        ticks(2);

        // Abort during the second pulse of a four-pulse run.
        set_cfg(2, 5, 3, 4);
        clear_stats();
        i_btn = 1'b1;
        wait_rises(2, 80, "abort-second-pulse");
        tick();
        i_arm_en = 1'b0;
        tick();
        chk("abort-pulse-low", o_pulse, 0);
        chk("abort-busy", o_busy, 1);
        ticks(20);
        i_arm_en = 1'b1;
        chk("abort-no-done", st_dones, 0);
        chk("abort-pulses", st_rises, 2);
        run_total = run_total + 16'd2;
        chk("abort-count", o_count, run_total);
        i_btn = 1'b0;
        wait_busy(1'b0, 40, "abort-idle");
        ticks(2);

        // Asynchronous reset in the middle of a pulse, button kept held.
        set_cfg(0, 20, 1, 1);
        clear_stats();
        i_btn = 1'b1;
        wait_rises(1, 40, "rst-pulse-start");
        ticks(3);
        #2;
        i_clk_reset = 1'b0;
        model_reset();
        #1;
        chk("rst-pulse-immediate", o_pulse, 0);
        chk("rst-all-zero", {o_busy, o_done, o_count}, 0);
        prev_pulse = 0; prev_busy = 0;
        ticks(3);
        i_clk_reset = 1'b1;
        clear_stats();
        wait_busy(1'b1, 40, "rst-held-retrigger");
        wait_done(60, "rst-run-done");
        chk("rst-count", o_count, 1);
        i_btn = 1'b0;
        wait_busy(1'b0, 40, "rst-idle");
        ticks(2);

        // Counter wrap from 0xFFFF.
        @(posedge i_clk);
        #2;
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        exp_count = 16'hFFFF;
        set_cfg(0, 1, 1, 1);
        clear_stats();
        i_btn = 1'b1;
        wait_done(40, "wrap-done");
        chk("wrap-count", o_count, 0);
        i_btn = 1'b0;
        wait_busy(1'b0, 40, "wrap-idle");
        ticks(2);

        // Width changed during DELAY must not affect the run.
        set_cfg(10, 5, 1, 1);
        clear_stats();
        i_btn = 1'b1;
        wait_busy(1'b1, 40, "latch-trigger");
        ticks(2);
        i_width = 16'd100;
        wait_done(200, "latch-done");
        chk("latch-width", st_high, 5);
        i_btn = 1'b0;
        wait_busy(1'b0, 40, "latch-idle");
        ticks(2);

        // Randomized presses, arm drops and setting changes against the model.
        for (int run = 0; run < 40; run++) begin
            set_cfg($urandom_range(0, 6), $urandom_range(0, 5),
                    $urandom_range(0, 4), $urandom_range(0, 4));
            i_arm_en = ($urandom_range(0, 7) != 0);
            nb = $urandom_range(0, 6);
            for (int j = 0; j < nb; j++) begin
                i_btn = ~i_btn;
                tick();
            end
            i_btn = 1'b1;
            hold = $urandom_range(10, 80);
            for (int j = 0; j < hold; j++) begin
                if ($urandom_range(0, 40) == 0) i_arm_en = 1'b0;
                else if (!i_arm_en && $urandom_range(0, 3) == 0) i_arm_en = 1'b1;
                if ($urandom_range(0, 15) == 0) i_width = 16'($urandom_range(0, 5));
                tick();
            end
            i_btn = 1'b0;
            i_arm_en = 1'b1;
            rel = $urandom_range(8, 20);
            ticks(rel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_glitch_pulse_gen
`default_nettype wire

// File: doc/glitch_pulse_gen.md
GLITCH_PULSE_GEN -- requirements
Module: glitch_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 2000000 (10 ms at 200 MHz), the number of stable cycles before a button level change is accepted.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for i_btn.
REQ-003 SHALL have port i_clk, input, 1 bit: the single 200 MHz clock; all logic runs on its rising edge.
REQ-004 SHALL have port i_clk_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_btn, input, 1 bit: raw asynchronous push button, active-high.
REQ-006 SHALL have port i_arm_en, input, 1 bit: enables triggering; deassertion aborts a run.
REQ-007 SHALL have ports i_delay, i_width and i_gap, each input, 16 bits, counted in clock cycles.
REQ-008 SHALL have port i_repeat, input, 8 bits: the number of pulses per trigger.
REQ-009 SHALL have port o_pulse, output, 1 bit: the glitch request, high for exactly the width window; feeds the glitcher pulse input.
REQ-010 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port o_done, output, 1 bit: one-cycle strobe marking a completed, non-aborted run.
REQ-012 SHALL have port o_count, output, 16 bits: total pulses started since reset.

Function
REQ-013 i_btn SHALL pass through SYNC_STAGES flops, then a debouncer whose output level changes only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronized value.
REQ-014 A run SHALL trigger on a debounced rising edge seen in IDLE with i_arm_en=1; edges seen in any other state SHALL be ignored.
REQ-015 At trigger, i_delay, i_width, i_gap and i_repeat SHALL be latched; later changes SHALL not affect the run.
REQ-016 Width 0, gap 0 and repeat 0 SHALL each be treated as 1; delay 0 is legal.
REQ-017 The FSM states SHALL be IDLE, DELAY, PULSE, GAP and HOLD.
REQ-018 For a trigger cycle T with latched values D, W, G and R, o_pulse SHALL be high in cycles T+1+D through T+D+W.
REQ-019 When R>1, each following pulse SHALL start after exactly G low cycles, giving R pulses in total.
REQ-020 The FSM SHALL go DELAY->PULSE, PULSE->GAP while pulses remain, GAP->PULSE, and the last PULSE->HOLD.
REQ-021 o_done SHALL be high for one cycle, the first cycle of HOLD, only when the run was not aborted.
REQ-022 HOLD SHALL go to IDLE on the first cycle the debounced button is low, so there is exactly one run per press.
REQ-023 If i_arm_en=0 in DELAY, PULSE or GAP, the FSM SHALL enter HOLD on the next cycle with o_pulse low and no o_done.
REQ-024 o_pulse SHALL be a registered output, glitch-free and driven from a flop.
REQ-025 o_count SHALL increment by 1 in the first cycle of each pulse and wrap from 0xFFFF to 0x0000.
REQ-026 An abort during PULSE SHALL keep the count for that pulse.

Reset
REQ-027 While i_clk_reset=0, the FSM SHALL be IDLE and o_pulse, o_busy, o_done and o_count SHALL all be 0.
REQ-028 While i_clk_reset=0, the synchronizer, the debounced level and all counters SHALL be 0.
REQ-029 Reset asserted mid-run SHALL drop o_pulse low immediately (asynchronously).
REQ-030 After reset releases, a button already held SHALL produce a trigger once the debounce completes.

Structure
REQ-031 A shared package glitch_pkg SHALL hold the FSM state encoding, the counter width (16) and the default DEBOUNCE_CYCLES.
REQ-032 The synchronizer and debouncer SHALL be one sub-module, btn_debounce, with outputs for the debounced level and a rise strobe.
REQ-033 Delay, width and gap SHALL share one 16-bit down-counter; the repeat count SHALL use a separate 8-bit down-counter.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Press with delay=0, width=1 and repeat=1 -> o_pulse high exactly one cycle, at T+1; o_done in the following cycle; o_count=1.
REQ-035 Press with delay=10, width=5, gap=3 and repeat=3 -> three 5-cycle pulses, first at T+11, separated by 3 low cycles; o_count=3.
REQ-036 Bounce i_btn with 2-cycle toggles for 30 cycles, then hold high -> exactly one trigger; held through HOLD -> no retrigger; release and re-press -> second run.
REQ-037 Drop i_arm_en during the 2nd pulse of a repeat=4 run -> o_pulse low next cycle, no o_done, o_count=2, back to IDLE after release.
REQ-038 Assert i_clk_reset mid-PULSE -> o_pulse=0 at once and all outputs 0; preload o_count=0xFFFF, then one pulse -> o_count=0x0000.
REQ-039 Change i_width from 5 to 100 during DELAY -> the pulse is still 5 cycles wide.
